// File: rtl/hack_pkg.sv
// Shared types and ISA field layout for the handshaked Hack CPU.
// Jump decoding is kept here so every user agrees on the condition codes.
package hack_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDread,
        StExec,
        StDwrite,
        StHalt
    } state_t;

    localparam int unsigned AbitPos = 12;
    localparam int unsigned CompMsb = 11;
    localparam int unsigned CompLsb = 6;
    localparam int unsigned DestA   = 5;
    localparam int unsigned DestD   = 4;
    localparam int unsigned DestM   = 3;

    localparam logic [2:0] JmpGt     = 3'b001;
    localparam logic [2:0] JmpEq     = 3'b010;
    localparam logic [2:0] JmpGe     = 3'b011;
    localparam logic [2:0] JmpLt     = 3'b100;
    localparam logic [2:0] JmpNe     = 3'b101;
    localparam logic [2:0] JmpLe     = 3'b110;
    localparam logic [2:0] JmpAlways = 3'b111;

    function automatic logic jump_taken(input logic [2:0] jump, input logic zr, input logic ng);
        logic taken;
        taken = 1'b0;
        case (jump)
            JmpGt:     taken = !zr && !ng;
            JmpEq:     taken = zr;
            JmpGe:     taken = !ng;
            JmpLt:     taken = ng;
            JmpNe:     taken = !zr;
            JmpLe:     taken = zr || ng;
            JmpAlways: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/hack_alu.sv
// Standard Hack ALU: zx/nx/zy/ny/f/no control over two WIDTH-bit operands.
module hack_alu #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic [5:0]       ctrl_i,
    output logic [WIDTH-1:0] out_o,
    output logic             zr_o,
    output logic             ng_o
);

    logic [WIDTH-1:0] xz, xn, yz, yn, f;

    always_comb begin
        xz    = ctrl_i[5] ? '0 : x_i;
        xn    = ctrl_i[4] ? ~xz : xz;
        yz    = ctrl_i[3] ? '0 : y_i;
        yn    = ctrl_i[2] ? ~yz : yz;
        f     = ctrl_i[1] ? (xn + yn) : (xn & yn);
        out_o = ctrl_i[0] ? ~f : f;
        zr_o  = (out_o == '0);
        ng_o  = out_o[WIDTH-1];
    end

endmodule

// File: rtl/hack_cpu_hs.sv
// Multicycle Hack CPU with valid/ready instruction and data ports, self-loop halt
// detection and a retired-instruction counter.
module hack_cpu_hs #(
    parameter int unsigned          WIDTH      = 16,
    parameter int unsigned          PC_WIDTH   = 16,
    parameter int unsigned          ADDR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0,
    parameter bit                   HALT_EN    = 1'b1,
    parameter int unsigned          CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [WIDTH-1:0]      imem_rdata,
    input  logic                  imem_ready,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0]      dmem_wdata,
    input  logic [WIDTH-1:0]      dmem_rdata,
    input  logic                  dmem_ready,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  retired
);
    import hack_pkg::*;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [WIDTH-1:0]      areg_q, areg_d, dreg_q, dreg_d;
    logic [WIDTH-1:0]      ir_q, ir_d, m_q, m_d;
    logic [CNT_WIDTH-1:0]  ret_q, ret_d;
    logic                  halt_pend_q, halt_pend_d;
    logic                  imem_req_q, imem_req_d;
    logic                  dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
    logic [ADDR_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
    logic [WIDTH-1:0]      dmem_wdata_q, dmem_wdata_d;

    logic [WIDTH-1:0]      alu_y, alu_out;
    logic                  alu_zr, alu_ng, halt_now;
    logic [PC_WIDTH-1:0]   old_a_pc;

    assign alu_y    = ir_q[AbitPos] ? m_q : areg_q;
    assign old_a_pc = areg_q[PC_WIDTH-1:0];

    hack_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .x_i   (dreg_q),
        .y_i   (alu_y),
        .ctrl_i(ir_q[CompMsb:CompLsb]),
        .out_o (alu_out),
        .zr_o  (alu_zr),
        .ng_o  (alu_ng)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        areg_d       = areg_q;
        dreg_d       = dreg_q;
        ir_d         = ir_q;
        m_d          = m_q;
        ret_d        = ret_q;
        halt_pend_d  = halt_pend_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        halt_now     = 1'b0;

        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                if (imem_ready) begin
                    ir_d = imem_rdata;
                    if (imem_rdata[WIDTH-1] && imem_rdata[AbitPos]) begin
                        state_d     = StDread;
                        dmem_addr_d = areg_q[ADDR_WIDTH-1:0];
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StDread: begin
                if (dmem_ready) begin
                    m_d     = dmem_rdata;
                    state_d = StExec;
                end
            end
            StExec: begin
                ret_d = ret_q + CNT_WIDTH'(1);
                if (!ir_q[WIDTH-1]) begin
                    areg_d  = ir_q;
                    pc_d    = pc_q + PC_WIDTH'(1);
                    state_d = StFetch;
                end else begin
                    // Jump target, M address and halt test all use A before this write.
                    if (ir_q[DestA]) areg_d = alu_out;
                    if (ir_q[DestD]) dreg_d = alu_out;
                    if (jump_taken(ir_q[2:0], alu_zr, alu_ng)) begin
                        pc_d     = old_a_pc;
                        halt_now = HALT_EN && (old_a_pc == pc_q);
                    end else begin
                        pc_d = pc_q + PC_WIDTH'(1);
                    end
                    if (ir_q[DestM]) begin
                        dmem_addr_d  = areg_q[ADDR_WIDTH-1:0];
                        dmem_wdata_d = alu_out;
                        halt_pend_d  = halt_now;
                        state_d      = StDwrite;
                    end else begin
                        state_d = halt_now ? StHalt : StFetch;
                    end
                end
            end
            StDwrite: begin
                if (dmem_ready) state_d = halt_pend_q ? StHalt : StFetch;
            end
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase

        // Requests come from the next state so they leave a flop, never decode logic.
        imem_req_d = (state_d == StFetch);
        dmem_req_d = (state_d == StDread) || (state_d == StDwrite);
        dmem_we_d  = (state_d == StDwrite);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            areg_q       <= '0;
            dreg_q       <= '0;
            ir_q         <= '0;
            m_q          <= '0;
            ret_q        <= '0;
            halt_pend_q  <= 1'b0;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            areg_q       <= areg_d;
            dreg_q       <= dreg_d;
            ir_q         <= ir_d;
            m_q          <= m_d;
            ret_q        <= ret_d;
            halt_pend_q  <= halt_pend_d;
            imem_req_q   <= imem_req_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign pc         = pc_q;
    assign halted     = (state_q == StHalt);
    assign retired    = ret_q;

endmodule

// File: tb/tb_hack_cpu_hs.sv
// Bench for hack_cpu_hs: wait-state memory models, hand vectors and random programs
// checked against an instruction-level Hack interpreter.
module tb_hack_cpu_hs;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, halted;
    logic [15:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc;
    logic [31:0] retired;

    always #5 clk = ~clk;

    hack_cpu_hs u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .imem_ready(imem_ready),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready),
        .pc        (pc),
        .halted    (halted),
        .retired   (retired)
    );

    logic [15:0] rom      [256];
    logic [15:0] ram_seed [256];
    logic [15:0] ram      [256];
    bit          rand_wait;
    int unsigned iw_fix, dw_fix, ilim, dlim, icnt, dcnt;

    assign imem_ready = imem_req && (icnt >= ilim);
    assign dmem_ready = dmem_req && (dcnt >= dlim);
    assign imem_rdata = rom[imem_addr[7:0]];
    assign dmem_rdata = ram[dmem_addr[7:0]];

    // Wait-state generator: ready rises after lim cycles of an outstanding request.
    always @(posedge clk) begin
        if (!reset_n) begin
            icnt <= 0;
            dcnt <= 0;
            ilim <= rand_wait ? $urandom_range(0, 2) : iw_fix;
            dlim <= rand_wait ? $urandom_range(0, 3) : dw_fix;
        end else begin
            icnt <= (imem_req && !imem_ready) ? icnt + 1 : 0;
            dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
            if (imem_req && imem_ready) ilim <= rand_wait ? $urandom_range(0, 2) : iw_fix;
            if (dmem_req && dmem_ready) dlim <= rand_wait ? $urandom_range(0, 3) : dw_fix;
        end
    end

    logic [15:0] flog[$];
    logic [31:0] wlog[$];
    int          rd_n, wr_n, rd_cyc, wr_cyc, stab_err, ovl_err;
    logic        pv_iw, pv_dw, pv_dwe;
    logic [15:0] pv_ia, pv_da, pv_dd;

    // Transaction monitor: handshakes complete on the posedge after this sample.
    always @(negedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) ram[i] <= ram_seed[i];
            flog.delete();
            wlog.delete();
            rd_n <= 0; wr_n <= 0; rd_cyc <= 0; wr_cyc <= 0; stab_err <= 0; ovl_err <= 0;
            pv_iw <= 1'b0; pv_dw <= 1'b0;
        end else begin
            if (imem_req && dmem_req) ovl_err <= ovl_err + 1;
            if (dmem_req && dmem_we) wr_cyc <= wr_cyc + 1;
            if (dmem_req && !dmem_we) rd_cyc <= rd_cyc + 1;
            stab_err <= stab_err
                + ((pv_iw && !(imem_req && imem_addr == pv_ia)) ? 1 : 0)
                + ((pv_dw && !(dmem_req && dmem_addr == pv_da && dmem_we == pv_dwe
                              && dmem_wdata == pv_dd)) ? 1 : 0);
            pv_iw <= imem_req && !imem_ready;
            pv_dw <= dmem_req && !dmem_ready;
            pv_ia <= imem_addr; pv_da <= dmem_addr; pv_dwe <= dmem_we; pv_dd <= dmem_wdata;
            if (imem_req && imem_ready) flog.push_back(imem_addr);
            if (dmem_req && dmem_ready) begin
                if (dmem_we) begin
                    ram[dmem_addr[7:0]] <= dmem_wdata;
                    wlog.push_back({dmem_addr, dmem_wdata});
                    wr_n <= wr_n + 1;
                end else begin
                    rd_n <= rd_n + 1;
                end
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Run until n instructions retired (or halt), then until the next fetch or halt.
    task automatic run_to(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk); #1;
            if (retired == 32'(n) || halted) begin ok = 1'b1; break; end
        end
        if (ok) begin
            ok = 1'b0;
            for (int c = 0; c < 100; c++) begin
                if (imem_req || halted) begin ok = 1'b1; break; end
                @(negedge clk); #1;
            end
        end
    endtask

    // Reference model: instruction-level Hack interpreter.
    function automatic logic [15:0] ref_alu(input logic [5:0] c, input logic [15:0] x,
                                            input logic [15:0] y);
        case (c)
            6'b101010: return 16'h0000;
            6'b111111: return 16'h0001;
            6'b111010: return 16'hFFFF;
            6'b001100: return x;
            6'b110000: return y;
            6'b001101: return ~x;
            6'b110001: return ~y;
            6'b001111: return -x;
            6'b110011: return -y;
            6'b011111: return x + 16'd1;
            6'b110111: return y + 16'd1;
            6'b001110: return x - 16'd1;
            6'b110010: return y - 16'd1;
            6'b000010: return x + y;
            6'b010011: return x - y;
            6'b000111: return y - x;
            6'b000000: return x & y;
            6'b010101: return x | y;
            default:   return 16'hxxxx;
        endcase
    endfunction

    logic [15:0] m_ram [256];
    logic [15:0] m_pc;
    int          m_ret;
    bit          m_halt;
    logic [15:0] exp_f[$];
    logic [31:0] exp_w[$];

    task automatic model_run(input int k);
        logic [15:0] a, d, ins, y, o, npc;
        bit          taken;
        a = 0; d = 0; m_pc = 0; m_ret = 0; m_halt = 1'b0;
        exp_f.delete();
        exp_w.delete();
        for (int i = 0; i < 256; i++) m_ram[i] = ram_seed[i];
        while (m_ret < k && !m_halt) begin
            ins = rom[m_pc[7:0]];
            exp_f.push_back(m_pc);
            if (!ins[15]) begin
                a = ins;
                m_pc = m_pc + 16'd1;
            end else begin
                y = ins[12] ? m_ram[a[7:0]] : a;
                o = ref_alu(ins[11:6], d, y);
                taken = (ins[2] && $signed(o) < 0) || (ins[1] && o == 0)
                     || (ins[0] && $signed(o) > 0);
                if (ins[3]) begin
                    m_ram[a[7:0]] = o;
                    exp_w.push_back({a, o});
                end
                npc = taken ? a : m_pc + 16'd1;
                if (taken && a == m_pc) m_halt = 1'b1;
                if (ins[5]) a = o;
                if (ins[4]) d = o;
                m_pc = npc;
            end
            m_ret++;
        end
    endtask

    typedef struct {
        logic [5:0][15:0] prog;
        logic [15:0]      maddr, mval;
        int               nret;
        logic [15:0]      epc;
        logic             ehalt;
        int               nrd, nwr;
        logic [31:0]      lastw;
        int               iw, dw;
    } vec_t;

    function automatic vec_t mkvec(input logic [15:0] p0, p1, p2, p3, p4,
                                   input logic [15:0] maddr, mval, input int nret,
                                   input logic [15:0] epc, input logic ehalt,
                                   input int nrd, nwr, input logic [31:0] lastw,
                                   input int iw, dw);
        vec_t v;
        v.prog = '0;
        v.prog[0] = p0; v.prog[1] = p1; v.prog[2] = p2; v.prog[3] = p3; v.prog[4] = p4;
        v.maddr = maddr; v.mval = mval; v.nret = nret; v.epc = epc; v.ehalt = ehalt;
        v.nrd = nrd; v.nwr = nwr; v.lastw = lastw; v.iw = iw; v.dw = dw;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs [6];
        logic [5:0]  comps [18];
        bit          ok;
        int          cnt, mism;

        comps = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
                  6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
                  6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};

        //                 p0       p1       p2       p3       p4       maddr    mval
        vecs[0] = mkvec(16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                        1, 16'h0001, 1'b0, 0, 0, 32'h0, 0, 0);
        vecs[1] = mkvec(16'h0003, 16'hEC10, 16'h0010, 16'hF088, 16'h0000, 16'h0010, 16'h0004,
                        4, 16'h0004, 1'b0, 1, 1, 32'h0010_0007, 1, 3);
        vecs[2] = mkvec(16'h0020, 16'hFDE8, 16'hEC10, 16'hE308, 16'h0000, 16'h0020, 16'h0041,
                        4, 16'h0004, 1'b0, 1, 2, 32'h0042_0042, 0, 1);
        vecs[3] = mkvec(16'hEE90, 16'h0030, 16'hE304, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                        3, 16'h0030, 1'b0, 0, 0, 32'h0, 0, 0);
        vecs[4] = mkvec(16'hEE90, 16'h0030, 16'hE301, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                        3, 16'h0003, 1'b0, 0, 0, 32'h0, 1, 0);
        vecs[5] = mkvec(16'h0000, 16'h0000, 16'h0000, 16'h0004, 16'hEA87, 16'h0000, 16'h0000,
                        5, 16'h0004, 1'b1, 0, 0, 32'h0, 2, 0);

        rand_wait = 1'b0; iw_fix = 0; dw_fix = 0;
        for (int i = 0; i < 256; i++) begin rom[i] = 16'h0; ram_seed[i] = 16'h0; end

        // Reset state and first-instruction timing.
        rom[0] = 16'h0005;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_pc", pc, 16'h0);
        check("rst_retired", retired, 32'h0);
        check("rst_reqs", {halted, imem_req, dmem_req, dmem_we}, 4'b0000);
        reset_n = 1'b1;
        @(negedge clk); #1;
        check("cyc1_imem_req", {imem_req, retired[0]}, 2'b10);
        @(negedge clk); #1;
        check("cyc2_exec_noreq", {imem_req, dmem_req}, 2'b00);
        @(negedge clk); #1;
        check("cyc3_retire", {pc, retired, imem_req}, {16'h0001, 32'h1, 1'b1});

        // Table vectors.
        foreach (vecs[k]) begin
            for (int i = 0; i < 256; i++) begin rom[i] = 16'h0; ram_seed[i] = 16'h0; end
            for (int i = 0; i < 6; i++) rom[i] = vecs[k].prog[i];
            ram_seed[vecs[k].maddr[7:0]] = vecs[k].mval;
            iw_fix = vecs[k].iw; dw_fix = vecs[k].dw;
            do_reset();
            run_to(vecs[k].nret, ok);
            check($sformatf("v%0d_done", k), ok, 1);
            check($sformatf("v%0d_pc", k), pc, vecs[k].epc);
            check($sformatf("v%0d_halted", k), halted, vecs[k].ehalt);
            check($sformatf("v%0d_retired", k), retired, vecs[k].nret);
            check($sformatf("v%0d_xfers", k), {rd_n, wr_n}, {vecs[k].nrd, vecs[k].nwr});
            check($sformatf("v%0d_hold", k), {rd_cyc, wr_cyc},
                  {vecs[k].nrd * (vecs[k].dw + 1), vecs[k].nwr * (vecs[k].dw + 1)});
            check($sformatf("v%0d_proto", k), {stab_err, ovl_err}, 64'h0);
            if (vecs[k].nwr > 0)
                check($sformatf("v%0d_lastw", k), wlog.size() > 0 ? wlog[wlog.size()-1] : 0,
                      vecs[k].lastw);
            if (vecs[k].ehalt) begin
                cnt = 0;
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk); #1;
                    if (imem_req || dmem_req) cnt++;
                end
                check("halt_no_req", cnt, 0);
                check("halt_frozen", {pc, retired, halted}, {vecs[k].epc, 32'(vecs[k].nret), 1'b1});
            end
        end

        // Reset while a write is waiting on ready.
        for (int i = 0; i < 256; i++) rom[i] = 16'h0;
        rom[0] = 16'h0010; rom[1] = 16'hE308;
        iw_fix = 0; dw_fix = 10;
        do_reset();
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); #1;
            if (dmem_req && dmem_we) begin ok = 1'b1; break; end
        end
        check("dw_reached", {ok, pc}, {1'b1, 16'h0002});
        #2 reset_n = 1'b0;
        #1;
        check("async_drop", {dmem_req, dmem_we, imem_req, pc}, {3'b000, 16'h0000});
        @(negedge clk); #1;
        reset_n = 1'b1;
        check("rel_idle", {imem_req, dmem_req}, 2'b00);
        @(negedge clk); #1;
        check("rel_fetch", {imem_req, imem_addr, retired}, {1'b1, 16'h0000, 32'h0});

        // Random programs with random wait states.
        rand_wait = 1'b1;
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 256; i++) begin
                ram_seed[i] = 16'($urandom);
                if ($urandom_range(0, 2) == 0)
                    rom[i] = {1'b0, 15'($urandom_range(0, 300))};
                else
                    rom[i] = {3'b111, 1'($urandom), comps[$urandom_range(0, 17)],
                              3'($urandom), ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000};
            end
            model_run(40);
            do_reset();
            run_to(m_ret, ok);
            check($sformatf("r%0d_done", r), ok, 1);
            check($sformatf("r%0d_state", r), {pc, retired, halted}, {m_pc, 32'(m_ret), m_halt});
            mism = 0;
            if (flog.size() < exp_f.size()) mism++;
            else foreach (exp_f[i]) if (flog[i] !== exp_f[i]) mism++;
            check($sformatf("r%0d_fetch_seq", r), mism, 0);
            mism = 0;
            if (wlog.size() != exp_w.size()) mism++;
            else foreach (exp_w[i]) if (wlog[i] !== exp_w[i]) mism++;
            check($sformatf("r%0d_write_seq", r), mism, 0);
            mism = 0;
            for (int i = 0; i < 256; i++) if (ram[i] !== m_ram[i]) mism++;
            check($sformatf("r%0d_ram", r), mism, 0);
            check($sformatf("r%0d_proto", r), {stab_err, ovl_err}, 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
